// File: rtl/down_counter_pkg.sv
// -----------------------------------------------------------------------------
// down_counter_pkg
// Purpose : shared types and constants for the loadable down-counter.
// Contents:
//   state_e        - FSM state encoding (IDLE, RUN, DONE), 2 bits
//   DEFAULT_WIDTH  - default counter width
// -----------------------------------------------------------------------------
package down_counter_pkg;

   localparam int DEFAULT_WIDTH = 4;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      RUN  = 2'd1,
      DONE = 2'd2
   } state_e;

endpackage : down_counter_pkg

// File: rtl/down_counter.sv
// -----------------------------------------------------------------------------
// down_counter
// Purpose : loadable WIDTH-bit down-counter used as a terminal-count / delay
//           timer. A start value is taken over a valid/ready handshake, the
//           count decrements once per enabled cycle, stops at zero and emits
//           a one-cycle done pulse.
// Ports   :
//   clk        in   1      clock, rising edge
//   rst        in   1      synchronous active-high reset
//   load_valid in   1      load request, load_val valid while high
//   load_ready out  1      a load can be accepted this cycle
//   load_val   in   WIDTH  start count (unsigned)
//   en         in   1      count enable in RUN
//   stop       in   1      synchronous abort of a running count
//   val        out  WIDTH  current count (registered)
//   busy       out  1      high while counting (RUN)
//   done       out  1      one-cycle pulse when the count reaches zero
// -----------------------------------------------------------------------------
module down_counter
   import down_counter_pkg::*;
#(
   parameter int WIDTH = DEFAULT_WIDTH
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             load_valid,
   output logic             load_ready,
   input  logic [WIDTH-1:0] load_val,
   input  logic             en,
   input  logic             stop,
   output logic [WIDTH-1:0] val,
   output logic             busy,
   output logic             done
);

   state_e           state_q, state_d;
   logic [WIDTH-1:0] val_q, val_d;
   logic             load_fire;

   // Handshake outputs depend only on the registered state, so no input
   // reaches an output combinationally.
   assign load_ready = (state_q != RUN);
   assign busy       = (state_q == RUN);
   assign done       = (state_q == DONE);
   assign val        = val_q;

   assign load_fire  = load_valid && load_ready;

   always_comb begin
      state_d = state_q;
      val_d   = val_q;
      unique case (state_q)
         IDLE, DONE: begin
            if (load_fire) begin
               val_d   = load_val;
               state_d = (load_val == '0) ? DONE : RUN;
            end else if (state_q == DONE) begin
               state_d = IDLE;
            end
         end
         RUN: begin
            // stop outranks en; the count is held where it was aborted.
            if (stop) begin
               state_d = IDLE;
            end else if (en) begin
               // Treat 0 like 1 so the count can never wrap, even from an
               // unexpected state.
               if (val_q <= WIDTH'(1)) begin
                  val_d   = '0;
                  state_d = DONE;
               end else begin
                  val_d = val_q - WIDTH'(1);
               end
            end
         end
         default: begin
            state_d = IDLE;
            val_d   = '0;
         end
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q <= IDLE;
         val_q   <= '0;
      end else begin
         state_q <= state_d;
         val_q   <= val_d;
      end
   end

endmodule : down_counter

// File: tb/tb_down_counter.sv
// -----------------------------------------------------------------------------
// tb_down_counter
// Directed bench for down_counter (WIDTH=4). Observed outputs are packed as
// {val, busy, done, load_ready} and compared against hand-computed vectors.
// -----------------------------------------------------------------------------
module tb_down_counter;

   localparam int W = 4;

   logic         clk = 1'b0;
   logic         rst;
   logic         load_valid;
   logic         load_ready;
   logic [W-1:0] load_val;
   logic         en;
   logic         stop;
   logic [W-1:0] val;
   logic         busy;
   logic         done;

   int checks = 0;
   int errors = 0;

   logic [W+2:0] exp_o;

   down_counter #(.WIDTH(W)) dut (
      .clk        (clk),
      .rst        (rst),
      .load_valid (load_valid),
      .load_ready (load_ready),
      .load_val   (load_val),
      .en         (en),
      .stop       (stop),
      .val        (val),
      .busy       (busy),
      .done       (done)
   );

   always #5 clk = ~clk;

   // Advance one rising edge, then settle 1 time unit before sampling/driving.
   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic test_reset();
      rst = 1'b1; load_valid = 1'b0; load_val = '0; en = 1'b0; stop = 1'b0;
      step(); step();
      exp_o = {4'd0, 1'b0, 1'b0, 1'b1};
      checks++;
      if ({val, busy, done, load_ready} !== exp_o) begin
         errors++;
         $display("FAIL reset_state got=%h exp=%h", {val, busy, done, load_ready}, exp_o);
      end
      // Load 5 with en low so it sits in RUN, then reset mid-count.
      rst = 1'b0; load_valid = 1'b1; load_val = 4'd5;
      step();
      load_valid = 1'b0;
      exp_o = {4'd5, 1'b1, 1'b0, 1'b0};
      checks++;
      if ({val, busy, done, load_ready} !== exp_o) begin
         errors++;
         $display("FAIL reset_preload got=%h exp=%h", {val, busy, done, load_ready}, exp_o);
      end
      rst = 1'b1; en = 1'b1;
      step();
      exp_o = {4'd0, 1'b0, 1'b0, 1'b1};
      checks++;
      if ({val, busy, done, load_ready} !== exp_o) begin
         errors++;
         $display("FAIL reset_midrun got=%h exp=%h", {val, busy, done, load_ready}, exp_o);
      end
      rst = 1'b0; en = 1'b0;
      step();
      checks++;
      if ({val, busy, done, load_ready} !== exp_o) begin
         errors++;
         $display("FAIL reset_no_done got=%h exp=%h", {val, busy, done, load_ready}, exp_o);
      end
   endtask

   task automatic test_count();
      logic [W-1:0] seq [4] = '{4'd3, 4'd2, 4'd1, 4'd0};
      load_valid = 1'b1; load_val = 4'd4; en = 1'b1;
      step();
      load_valid = 1'b0;
      exp_o = {4'd4, 1'b1, 1'b0, 1'b0};
      checks++;
      if ({val, busy, done, load_ready} !== exp_o) begin
         errors++;
         $display("FAIL count_load got=%h exp=%h", {val, busy, done, load_ready}, exp_o);
      end
      for (int i = 0; i < 4; i++) begin
         step();
         exp_o = (i == 3) ? {4'd0, 1'b0, 1'b1, 1'b1} : {seq[i], 1'b1, 1'b0, 1'b0};
         checks++;
         if ({val, busy, done, load_ready} !== exp_o) begin
            errors++;
            $display("FAIL count_step%0d got=%h exp=%h", i, {val, busy, done, load_ready}, exp_o);
         end
      end
      step();
      exp_o = {4'd0, 1'b0, 1'b0, 1'b1};
      checks++;
      if ({val, busy, done, load_ready} !== exp_o) begin
         errors++;
         $display("FAIL count_after_done got=%h exp=%h", {val, busy, done, load_ready}, exp_o);
      end
   endtask

   task automatic test_enable_toggle();
      logic [W-1:0] exp_v;
      load_valid = 1'b1; load_val = 4'd6; en = 1'b0;
      step();
      load_valid = 1'b0;
      exp_v = 4'd6;
      // en alternates 1,0,1,0...; the sixth enabled cycle is i=10.
      for (int i = 0; i < 12; i++) begin
         en = (i % 2 == 0);
         step();
         if (en && exp_v != 0) exp_v = exp_v - 4'd1;
         if (i < 10)       exp_o = {exp_v, 1'b1, 1'b0, 1'b0};
         else if (i == 10) exp_o = {4'd0, 1'b0, 1'b1, 1'b1};
         else              exp_o = {4'd0, 1'b0, 1'b0, 1'b1};
         checks++;
         if ({val, busy, done, load_ready} !== exp_o) begin
            errors++;
            $display("FAIL en_toggle_%0d got=%h exp=%h", i, {val, busy, done, load_ready}, exp_o);
         end
      end
      en = 1'b0;
   endtask

   task automatic test_zero_load();
      load_valid = 1'b1; load_val = 4'd0; en = 1'b1;
      step();
      load_valid = 1'b0;
      exp_o = {4'd0, 1'b0, 1'b1, 1'b1};
      checks++;
      if ({val, busy, done, load_ready} !== exp_o) begin
         errors++;
         $display("FAIL zero_load_done got=%h exp=%h", {val, busy, done, load_ready}, exp_o);
      end
      step();
      exp_o = {4'd0, 1'b0, 1'b0, 1'b1};
      checks++;
      if ({val, busy, done, load_ready} !== exp_o) begin
         errors++;
         $display("FAIL zero_load_after got=%h exp=%h", {val, busy, done, load_ready}, exp_o);
      end
   endtask

   task automatic test_stop();
      load_valid = 1'b1; load_val = 4'd3; en = 1'b1;
      step();
      load_valid = 1'b0;
      step();
      exp_o = {4'd2, 1'b1, 1'b0, 1'b0};
      checks++;
      if ({val, busy, done, load_ready} !== exp_o) begin
         errors++;
         $display("FAIL stop_pre got=%h exp=%h", {val, busy, done, load_ready}, exp_o);
      end
      stop = 1'b1;
      step();
      stop = 1'b0;
      exp_o = {4'd2, 1'b0, 1'b0, 1'b1};
      for (int i = 0; i < 3; i++) begin
         checks++;
         if ({val, busy, done, load_ready} !== exp_o) begin
            errors++;
            $display("FAIL stop_hold%0d got=%h exp=%h", i, {val, busy, done, load_ready}, exp_o);
         end
         step();
      end
      load_valid = 1'b1; load_val = 4'd1;
      step();
      load_valid = 1'b0;
      exp_o = {4'd1, 1'b1, 1'b0, 1'b0};
      checks++;
      if ({val, busy, done, load_ready} !== exp_o) begin
         errors++;
         $display("FAIL stop_reload got=%h exp=%h", {val, busy, done, load_ready}, exp_o);
      end
      step();
      exp_o = {4'd0, 1'b0, 1'b1, 1'b1};
      checks++;
      if ({val, busy, done, load_ready} !== exp_o) begin
         errors++;
         $display("FAIL stop_reload_done got=%h exp=%h", {val, busy, done, load_ready}, exp_o);
      end
      step();
   endtask

   task automatic test_back_to_back();
      load_valid = 1'b1; load_val = 4'd15; en = 1'b1;
      step();
      exp_o = {4'd15, 1'b1, 1'b0, 1'b0};
      checks++;
      if ({val, busy, done, load_ready} !== exp_o) begin
         errors++;
         $display("FAIL b2b_load15 got=%h exp=%h", {val, busy, done, load_ready}, exp_o);
      end
      // Hold a pending load of 2 through RUN; it must only land in DONE.
      load_val = 4'd2;
      for (int i = 14; i >= 0; i--) begin
         step();
         exp_o = (i == 0) ? {4'd0, 1'b0, 1'b1, 1'b1} : {4'(i), 1'b1, 1'b0, 1'b0};
         checks++;
         if ({val, busy, done, load_ready} !== exp_o) begin
            errors++;
            $display("FAIL b2b_run_v%0d got=%h exp=%h", i, {val, busy, done, load_ready}, exp_o);
         end
      end
      step();
      load_valid = 1'b0;
      exp_o = {4'd2, 1'b1, 1'b0, 1'b0};
      checks++;
      if ({val, busy, done, load_ready} !== exp_o) begin
         errors++;
         $display("FAIL b2b_second_load got=%h exp=%h", {val, busy, done, load_ready}, exp_o);
      end
      step();
      exp_o = {4'd1, 1'b1, 1'b0, 1'b0};
      checks++;
      if ({val, busy, done, load_ready} !== exp_o) begin
         errors++;
         $display("FAIL b2b_v1 got=%h exp=%h", {val, busy, done, load_ready}, exp_o);
      end
      step();
      exp_o = {4'd0, 1'b0, 1'b1, 1'b1};
      checks++;
      if ({val, busy, done, load_ready} !== exp_o) begin
         errors++;
         $display("FAIL b2b_done2 got=%h exp=%h", {val, busy, done, load_ready}, exp_o);
      end
      step();
      exp_o = {4'd0, 1'b0, 1'b0, 1'b1};
      checks++;
      if ({val, busy, done, load_ready} !== exp_o) begin
         errors++;
         $display("FAIL b2b_idle got=%h exp=%h", {val, busy, done, load_ready}, exp_o);
      end
   endtask

   initial begin
      test_reset();
      test_count();
      test_enable_toggle();
      test_zero_load();
      test_stop();
      test_back_to_back();
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule : tb_down_counter
